// File: rtl/up_bus_agg_pkg.sv
// Shared types and helpers for the up-bus aggregation stage and its
// per-path transfer trackers.
package up_bus_agg_pkg;

    typedef enum logic [1:0] {
        XFER_IDLE = 2'd0,
        XFER_WAIT = 2'd1,
        XFER_RESP = 2'd2
    } xfer_state_t;

    localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_DEAD;

    // True when more than one bit of the ack vector is set.
    function automatic logic multi_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/up_xfer_tracker.sv
// One up-bus transfer path: request broadcast, ack/timeout tracking and
// per-cycle fault pulses. Instantiated once for reads, once for writes.
module up_xfer_tracker
    import up_bus_agg_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 14,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          NUM_SLAVES     = 3,
    parameter int          DATA_EN        = 1,
    parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_data,
    input  logic [NUM_SLAVES-1:0] i_ack,
    input  logic [31:0]           i_rdata,
    output logic                  o_s_req,
    output logic [ADDR_WIDTH-1:0] o_s_addr,
    output logic [31:0]           o_s_data,
    output logic                  o_ack,
    output logic [31:0]           o_rdata,
    output logic                  o_busy_nxt,
    output logic                  o_multi,
    output logic                  o_stray,
    output logic                  o_overrun,
    output logic                  o_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    xfer_state_t           r_state;
    xfer_state_t           w_next;
    logic [TW-1:0]         r_timer;
    logic                  r_s_req;
    logic [ADDR_WIDTH-1:0] r_s_addr;
    logic [31:0]           r_s_data;
    logic                  r_ack;
    logic [31:0]           r_rdata;
    logic                  w_accept;
    logic                  w_to_resp;
    logic [31:0]           w_resp_data;
    logic                  w_any_ack;

    assign w_any_ack = |i_ack;

    // Next-state, response capture and fault detection for this path.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_to_resp   = 1'b0;
        w_resp_data = 32'd0;
        o_multi     = 1'b0;
        o_timeout   = 1'b0;
        case (r_state)
            XFER_IDLE: begin
                if (i_req) begin
                    w_next   = XFER_WAIT;
                    w_accept = 1'b1;
                end else begin
                    w_next = XFER_IDLE;
                end
            end
            XFER_WAIT: begin
                // An ack arriving on the last timer cycle still wins.
                if (w_any_ack) begin
                    w_next      = XFER_RESP;
                    w_to_resp   = 1'b1;
                    w_resp_data = (DATA_EN != 0) ? i_rdata : 32'd0;
                    o_multi     = multi_hot(32'(i_ack));
                end else if (r_timer == TIMER_LAST) begin
                    w_next      = XFER_RESP;
                    w_to_resp   = 1'b1;
                    w_resp_data = (DATA_EN != 0) ? TIMEOUT_DATA : 32'd0;
                    o_timeout   = 1'b1;
                end else begin
                    w_next = XFER_WAIT;
                end
            end
            XFER_RESP: begin
                w_next = XFER_IDLE;
            end
            default: begin
                w_next = XFER_IDLE;
            end
        endcase
        o_stray    = w_any_ack && (r_state != XFER_WAIT);
        o_overrun  = i_req && (r_state != XFER_IDLE);
        o_busy_nxt = (w_next != XFER_IDLE);
    end

    // State, timer, broadcast request and registered response.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= XFER_IDLE;
            r_timer  <= {TW{1'b0}};
            r_s_req  <= 1'b0;
            r_s_addr <= {ADDR_WIDTH{1'b0}};
            r_s_data <= 32'd0;
            r_ack    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_timer <= {TW{1'b0}};
            end else if (r_state == XFER_WAIT) begin
                r_timer <= r_timer + TW'(1'b1);
            end else begin
                r_timer <= r_timer;
            end
            r_s_req <= w_accept;
            if (w_accept) begin
                r_s_addr <= i_addr;
                r_s_data <= i_data;
            end else begin
                r_s_addr <= r_s_addr;
                r_s_data <= r_s_data;
            end
            r_ack   <= w_to_resp;
            r_rdata <= w_to_resp ? w_resp_data : 32'd0;
        end
    end

    assign o_s_req  = r_s_req;
    assign o_s_addr = r_s_addr;
    assign o_s_data = r_s_data;
    assign o_ack    = r_ack;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/up_bus_agg.sv
// Up-bus aggregation stage: broadcasts requests to NUM_SLAVES register slices,
// OR-combines their acks/data and reports protocol faults and timeouts.
module up_bus_agg
    import up_bus_agg_pkg::*;
#(
    parameter int          NUM_SLAVES     = 3,
    parameter int          ADDR_WIDTH     = 14,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA,
    parameter int          CNT_WIDTH      = 8
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     up_wreq,
    input  logic                     up_rreq,
    input  logic [ADDR_WIDTH-1:0]    up_waddr,
    input  logic [ADDR_WIDTH-1:0]    up_raddr,
    input  logic [31:0]              up_wdata,
    output logic                     up_wack,
    output logic                     up_rack,
    output logic [31:0]              up_rdata,
    output logic                     s_wreq,
    output logic                     s_rreq,
    output logic [ADDR_WIDTH-1:0]    s_waddr,
    output logic [ADDR_WIDTH-1:0]    s_raddr,
    output logic [31:0]              s_wdata,
    input  logic [NUM_SLAVES-1:0]    s_wack,
    input  logic [NUM_SLAVES-1:0]    s_rack,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic                     err_clr,
    output logic                     busy,
    output logic                     err_multi,
    output logic                     err_stray,
    output logic                     err_overrun,
    output logic [CNT_WIDTH-1:0]     timeout_cnt
);

    localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

    logic [31:0]          w_rd_or;
    logic [31:0]          w_rd_sdata_unused;
    logic [31:0]          w_wr_rdata_unused;
    logic                 w_rd_busy_nxt, w_wr_busy_nxt;
    logic                 w_rd_multi, w_wr_multi;
    logic                 w_rd_stray, w_wr_stray;
    logic                 w_rd_overrun, w_wr_overrun;
    logic                 w_rd_timeout, w_wr_timeout;
    logic [CNT_WIDTH-1:0] w_cnt_base;
    logic [CNT_WIDTH:0]   w_cnt_sum;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 r_busy;
    logic                 r_err_multi, r_err_stray, r_err_overrun;
    logic [CNT_WIDTH-1:0] r_timeout_cnt;

    // Read data OR-reduction; non-acking slaves are masked out.
    always_comb begin
        w_rd_or = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_rd_or = w_rd_or | (s_rdata[32*i +: 32] & {32{s_rack[i]}});
        end
    end

    up_xfer_tracker #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NUM_SLAVES     (NUM_SLAVES),
        .DATA_EN        (1),
        .TIMEOUT_DATA   (TIMEOUT_DATA)
    ) u_rd (
        .i_clk      (up_clk),
        .i_rstn     (up_rstn),
        .i_req      (up_rreq),
        .i_addr     (up_raddr),
        .i_data     (32'd0),
        .i_ack      (s_rack),
        .i_rdata    (w_rd_or),
        .o_s_req    (s_rreq),
        .o_s_addr   (s_raddr),
        .o_s_data   (w_rd_sdata_unused),
        .o_ack      (up_rack),
        .o_rdata    (up_rdata),
        .o_busy_nxt (w_rd_busy_nxt),
        .o_multi    (w_rd_multi),
        .o_stray    (w_rd_stray),
        .o_overrun  (w_rd_overrun),
        .o_timeout  (w_rd_timeout)
    );

    up_xfer_tracker #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NUM_SLAVES     (NUM_SLAVES),
        .DATA_EN        (0),
        .TIMEOUT_DATA   (TIMEOUT_DATA)
    ) u_wr (
        .i_clk      (up_clk),
        .i_rstn     (up_rstn),
        .i_req      (up_wreq),
        .i_addr     (up_waddr),
        .i_data     (up_wdata),
        .i_ack      (s_wack),
        .i_rdata    (32'd0),
        .o_s_req    (s_wreq),
        .o_s_addr   (s_waddr),
        .o_s_data   (s_wdata),
        .o_ack      (up_wack),
        .o_rdata    (w_wr_rdata_unused),
        .o_busy_nxt (w_wr_busy_nxt),
        .o_multi    (w_wr_multi),
        .o_stray    (w_wr_stray),
        .o_overrun  (w_wr_overrun),
        .o_timeout  (w_wr_timeout)
    );

    // Clear first, then add this cycle's timeouts, saturating at all-ones.
    always_comb begin
        w_cnt_base = err_clr ? {CNT_WIDTH{1'b0}} : r_timeout_cnt;
        w_cnt_sum  = {1'b0, w_cnt_base} + (CNT_WIDTH+1)'(w_rd_timeout)
                                        + (CNT_WIDTH+1)'(w_wr_timeout);
        if (w_cnt_sum > CNT_MAX) begin
            w_cnt_next = CNT_MAX[CNT_WIDTH-1:0];
        end else begin
            w_cnt_next = w_cnt_sum[CNT_WIDTH-1:0];
        end
    end

    // Sticky fault flags, timeout counter and busy.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_busy        <= 1'b0;
            r_err_multi   <= 1'b0;
            r_err_stray   <= 1'b0;
            r_err_overrun <= 1'b0;
            r_timeout_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            r_busy        <= w_rd_busy_nxt | w_wr_busy_nxt;
            r_err_multi   <= (r_err_multi & ~err_clr) | w_rd_multi | w_wr_multi;
            r_err_stray   <= (r_err_stray & ~err_clr) | w_rd_stray | w_wr_stray;
            r_err_overrun <= (r_err_overrun & ~err_clr) | w_rd_overrun | w_wr_overrun;
            r_timeout_cnt <= w_cnt_next;
        end
    end

    assign busy        = r_busy;
    assign err_multi   = r_err_multi;
    assign err_stray   = r_err_stray;
    assign err_overrun = r_err_overrun;
    assign timeout_cnt = r_timeout_cnt;

endmodule
